int_to_fp_convert: RTL



---
 rtl/fpu_pkg.sv | 16 +
 rtl/int_to_fp_convert_if.sv | 22 ++
 rtl/dp_round_rne.sv | 29 ++
 rtl/int_to_fp_convert.sv | 94 +++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared double-precision constants and converter state encoding for the FPU slice.
package fpu_pkg;

    localparam int unsigned DP_EXP_W    = 11;
    localparam int unsigned DP_FRAC_W   = 52;
    localparam int unsigned DP_BIAS     = 1023;
    // Exponent of a value whose leading one sits in bit 63 (bias + 63).
    localparam int unsigned DP_INT_EXP0 = 1086;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND
    } cvt_state_e;

endpackage

// File: rtl/int_to_fp_convert_if.sv
// Start/busy/done handshake and data bus of the integer-to-double converter.
interface int_to_fp_convert_if;

    logic        start;
    logic        is_signed;
    logic [63:0] int_in;
    logic [63:0] fp_out;
    logic        busy;
    logic        done;
    logic        inexact;

    modport master (
        output start, is_signed, int_in,
        input  fp_out, busy, done, inexact
    );

    modport slave (
        input  start, is_signed, int_in,
        output fp_out, busy, done, inexact
    );

endinterface

// File: rtl/dp_round_rne.sv
// Round-to-nearest-even of a normalised 64-bit magnitude into a double {exp, frac} field.
module dp_round_rne
    import fpu_pkg::*;
(
    input  logic [63:0]                   mag_i,
    input  logic [DP_EXP_W-1:0]           exp_i,
    output logic [DP_EXP_W+DP_FRAC_W-1:0] exp_frac_o,
    output logic                          inexact_o
);

    logic lsb;
    logic guard;
    logic sticky;
    logic round_up;

    assign lsb      = mag_i[11];
    assign guard    = mag_i[10];
    assign sticky   = |mag_i[9:0];
    assign round_up = guard & (sticky | lsb);

    // The hidden bit mag_i[63] is added arithmetically on top of exp-1, so a
    // fraction carry-out naturally increments the exponent field.
    assign exp_frac_o = {exp_i - DP_EXP_W'(1), {DP_FRAC_W{1'b0}}}
                      + {{(DP_EXP_W-1){1'b0}}, mag_i[63:11]}
                      + (DP_EXP_W+DP_FRAC_W)'(round_up);

    assign inexact_o = guard | sticky;

endmodule

// File: rtl/int_to_fp_convert.sv
// Multi-cycle signed/unsigned 64-bit integer to IEEE-754 double converter (iterative normalise, RNE).
module int_to_fp_convert
    import fpu_pkg::*;
#(
    parameter int unsigned NORM_STEP = 8
) (
    input  logic                clk,
    input  logic                reset,
    int_to_fp_convert_if.slave  bus
);

    localparam logic [DP_EXP_W-1:0] EXP0   = DP_EXP_W'(DP_INT_EXP0);
    localparam logic [DP_EXP_W-1:0] STEP_E = DP_EXP_W'(NORM_STEP);

    cvt_state_e          state_q;
    logic                sign_q;
    logic                zero_q;
    logic [63:0]         mag_q;
    logic [DP_EXP_W-1:0] exp_q;
    logic [63:0]         fp_out_q;
    logic                busy_q;
    logic                done_q;
    logic                inexact_q;

    logic                sign_d;
    logic [63:0]         mag_d;
    logic [DP_EXP_W+DP_FRAC_W-1:0] rnd_exp_frac;
    logic                rnd_inexact;

    always_comb begin
        sign_d = bus.is_signed & bus.int_in[63];
        mag_d  = sign_d ? (~bus.int_in + 64'd1) : bus.int_in;
    end

    dp_round_rne u_round (
        .mag_i      (mag_q),
        .exp_i      (exp_q),
        .exp_frac_o (rnd_exp_frac),
        .inexact_o  (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            fp_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sign_q  <= sign_d;
                        mag_q   <= mag_d;
                        exp_q   <= EXP0;
                        zero_q  <= (mag_d == '0);
                        busy_q  <= 1'b1;
                        state_q <= (mag_d == '0) ? ROUND : NORM;
                    end
                end
                NORM: begin
                    if (mag_q[63 -: NORM_STEP] == '0) begin
                        mag_q <= mag_q << NORM_STEP;
                        exp_q <= exp_q - STEP_E;
                    end else if (!mag_q[63]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - DP_EXP_W'(1);
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    fp_out_q  <= zero_q ? '0 : {sign_q, rnd_exp_frac};
                    inexact_q <= zero_q ? 1'b0 : rnd_inexact;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fp_out  = fp_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.inexact = inexact_q;

endmodule
